// File: rtl/imem_access_arbiter.sv
// Single-owner sequencer for the instruction memory's shared port: grants loader
// writes and fetch reads one at a time and bounds loader bursts so fetch cannot starve.
module imem_access_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ack,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ack,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_enable,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  busy
);

    // Handshake: requests are levels held until their ack; each ack is a one-cycle
    // pulse raised after the accepting edge, while the FSM is already out of IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD1  = 2'd2,
        RD2  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  load_ack_q, load_ack_d;
    logic                  fetch_ack_q, fetch_ack_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic [3:0]            burst_cnt_q, burst_cnt_d;
    logic                  busy_q, busy_d;
    logic                  grant_write;

    // Loader wins unless fetch is waiting and the loader has used up its burst.
    assign grant_write = load_req && (!fetch_req || (burst_cnt_q < 4'(MAX_BURST)));

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        wdata_d       = wdata_q;
        mem_we_d      = 1'b0;
        load_ack_d    = 1'b0;
        fetch_ack_d   = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        burst_cnt_d   = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (!fetch_req) begin
                    burst_cnt_d = '0;
                end
                if (grant_write) begin
                    mem_addr_d = load_addr;
                    wdata_d    = load_data;
                    mem_we_d   = 1'b1;
                    load_ack_d = 1'b1;
                    state_d    = WR;
                    if (fetch_req) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end
                end else if (fetch_req) begin
                    mem_addr_d  = fetch_addr;
                    fetch_ack_d = 1'b1;
                    burst_cnt_d = '0;
                    state_d     = RD1;
                end
            end
            WR:  state_d = IDLE;
            RD1: state_d = RD2;
            RD2: begin
                // Memory latched the word at the RD1->RD2 edge and drives it now.
                fetch_data_d  = mem_data;
                fetch_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            wdata_q       <= '0;
            mem_we_q      <= 1'b0;
            load_ack_q    <= 1'b0;
            fetch_ack_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            burst_cnt_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            wdata_q       <= wdata_d;
            mem_we_q      <= mem_we_d;
            load_ack_q    <= load_ack_d;
            fetch_ack_q   <= fetch_ack_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            burst_cnt_q   <= burst_cnt_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_data         = mem_we_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign mem_addr         = mem_addr_q;
    assign mem_write_enable = mem_we_q;
    assign load_ack         = load_ack_q;
    assign fetch_ack        = fetch_ack_q;
    assign fetch_valid      = fetch_valid_q;
    assign fetch_data       = fetch_data_q;
    assign busy             = busy_q;

endmodule
